// File: rtl/pll_mode_switch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pll_mode_switch: reprograms the system PLL between NTSC and PAL clk_sys     |
// | rates and holds tv_reset until the new clock is locked and stable.          |
// | Optional: PLL_MODE_SWITCH_READBACK_EN adds read-after-write verification.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pll_mode_switch #(
  parameter int          INIT_CFG     = 1,
  parameter int          HOLD_CYCLES  = 1024,
  parameter int          UNLOCK_WAIT  = 64,
  parameter int          LOCK_TIMEOUT = 1000000,
  parameter logic [31:0] C0_NTSC      = 32'h00000505,
  parameter logic [31:0] C0_PAL       = 32'h00020504,
  parameter logic [31:0] MFRAC_NTSC   = 32'h9745BF27,
  parameter logic [31:0] MFRAC_PAL    = 32'hA3D709E8
) (
  input  logic        CLK_50M,
  input  logic        reset_n,
  input  logic        pal,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
`ifdef PLL_MODE_SWITCH_READBACK_EN
  output logic        mgmt_read,
  input  logic [31:0] mgmt_readdata,
`endif
  output logic        tv_reset,
  output logic        busy,
  output logic        done,
  output logic        lock_err,
  output logic        cfg_err
);

  localparam logic [2:0]  c_ST_IDLE        = 3'd0;
  localparam logic [2:0]  c_ST_WRITE       = 3'd1;
`ifdef PLL_MODE_SWITCH_READBACK_EN
  localparam logic [2:0]  c_ST_READ        = 3'd2;
`endif
  localparam logic [2:0]  c_ST_WAIT_UNLOCK = 3'd3;
  localparam logic [2:0]  c_ST_WAIT_LOCK   = 3'd4;
  localparam logic [2:0]  c_ST_HOLD        = 3'd5;
  localparam logic [2:0]  c_LAST_IDX       = 3'd5;
  localparam logic [31:0] c_UNLOCK_LAST    = 32'(UNLOCK_WAIT - 1);
  localparam logic [31:0] c_TIMEOUT_LAST   = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0] c_HOLD_LAST      = 32'(HOLD_CYCLES - 1);

  logic        r_pal_meta, r_pal_s, r_lock_meta, r_lock_s;
  logic [2:0]  r_state;
  logic        r_mode_cur;
  logic [2:0]  r_idx;
  logic        r_wr;
  logic [5:0]  r_addr;
  logic [31:0] r_data;
  logic [31:0] r_cnt;
  logic        r_tv_reset, r_busy, r_done, r_lock_err;
  logic [5:0]  w_addr;
  logic [31:0] w_data;

  // Synchronizers are not reset so the reset branch can sample a settled pal level.
  always_ff @(posedge CLK_50M) begin
    r_pal_meta  <= pal;
    r_pal_s     <= r_pal_meta;
    r_lock_meta <= pll_locked;
    r_lock_s    <= r_lock_meta;
  end

  always_comb begin
    w_addr = 6'd0;
    w_data = 32'd0;
    case (r_idx)
      3'd1:    begin w_addr = 6'd3; w_data = 32'h00010000; end
      3'd2:    begin w_addr = 6'd4; w_data = 32'h00000404; end
      3'd3:    begin w_addr = 6'd5; w_data = r_mode_cur ? C0_PAL : C0_NTSC; end
      3'd4:    begin w_addr = 6'd7; w_data = r_mode_cur ? MFRAC_PAL : MFRAC_NTSC; end
      3'd5:    begin w_addr = 6'd2; w_data = 32'd0; end
      default: begin w_addr = 6'd0; w_data = 32'd0; end
    endcase
  end

`ifdef PLL_MODE_SWITCH_READBACK_EN
  logic r_rd;
  logic r_cfg_err;
  logic w_verify;
  assign w_verify = (r_idx >= 3'd1) && (r_idx <= 3'd4);
`endif

  always_ff @(posedge CLK_50M) begin
    if (!reset_n) begin
      r_state    <= c_ST_IDLE;
      r_mode_cur <= (INIT_CFG != 0) ? ~r_pal_s : r_pal_s;
      r_idx      <= 3'd0;
      r_wr       <= 1'b0;
      r_addr     <= 6'd0;
      r_data     <= 32'd0;
      r_cnt      <= 32'd0;
      r_tv_reset <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_lock_err <= 1'b0;
`ifdef PLL_MODE_SWITCH_READBACK_EN
      r_rd       <= 1'b0;
      r_cfg_err  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (r_pal_s != r_mode_cur) begin
            r_mode_cur <= r_pal_s;
            r_tv_reset <= 1'b1;
            r_busy     <= 1'b1;
            r_idx      <= 3'd0;
            r_state    <= c_ST_WRITE;
          end
        end
        c_ST_WRITE: begin
          if (!r_wr) begin
            r_wr   <= 1'b1;
            r_addr <= w_addr;
            r_data <= w_data;
          end else if (!mgmt_waitrequest) begin
            r_wr <= 1'b0;
            if (r_idx == c_LAST_IDX) begin
              r_cnt   <= 32'd0;
              r_state <= c_ST_WAIT_UNLOCK;
            end else begin
`ifdef PLL_MODE_SWITCH_READBACK_EN
              if (w_verify) r_state <= c_ST_READ;
              else          r_idx   <= r_idx + 3'd1;
`else
              r_idx <= r_idx + 3'd1;
`endif
            end
          end
        end
`ifdef PLL_MODE_SWITCH_READBACK_EN
        c_ST_READ: begin
          if (!r_rd) begin
            r_rd <= 1'b1;
          end else if (!mgmt_waitrequest) begin
            r_rd <= 1'b0;
            if (mgmt_readdata != r_data) r_cfg_err <= 1'b1;
            r_idx   <= r_idx + 3'd1;
            r_state <= c_ST_WRITE;
          end
        end
`endif
        c_ST_WAIT_UNLOCK: begin
          if (!r_lock_s || (r_cnt == c_UNLOCK_LAST)) begin
            r_cnt   <= 32'd0;
            r_state <= c_ST_WAIT_LOCK;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        c_ST_WAIT_LOCK: begin
          // The cycle that sees lock counts as the first stable cycle.
          if (r_lock_s) begin
            r_cnt   <= 32'd1;
            r_state <= c_ST_HOLD;
          end else if (r_cnt == c_TIMEOUT_LAST) begin
            r_lock_err <= 1'b1;
            r_cnt      <= 32'd0;
            r_state    <= c_ST_HOLD;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        c_ST_HOLD: begin
          if (!r_lock_s) begin
            r_cnt <= 32'd0;
          end else if (r_cnt >= c_HOLD_LAST) begin
            r_tv_reset <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= c_ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign mgmt_write     = r_wr;
  assign mgmt_address   = r_addr;
  assign mgmt_writedata = r_data;
  assign tv_reset       = r_tv_reset;
  assign busy           = r_busy;
  assign done           = r_done;
  assign lock_err       = r_lock_err;
`ifdef PLL_MODE_SWITCH_READBACK_EN
  assign mgmt_read      = r_rd;
  assign cfg_err        = r_cfg_err;
`else
  assign cfg_err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_mode_switch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pll_mode_switch: scoreboard bench for pll_mode_switch write sequences,   |
// | lock hold/timeout handling and reset abort.                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pll_mode_switch;

  localparam int HOLD = 16;
  localparam int UNLOCK = 8;
  localparam int TIMEOUT = 200;

  logic        CLK_50M = 1'b0;
  logic        reset_n, pal, pll_locked, mgmt_waitrequest;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        tv_reset, busy, done, lock_err, cfg_err;
`ifdef PLL_MODE_SWITCH_READBACK_EN
  logic        mgmt_read;
  logic [31:0] mgmt_readdata;
  logic        corrupt;
  logic [31:0] mem [0:7];
`endif

  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q[$];
  logic [37:0] exp_item;
  logic        stall_en, prev_stall;
  int          stall_cnt, wr4_cycles;
  logic [5:0]  prev_addr;
  logic [31:0] prev_data;

  pll_mode_switch #(
    .INIT_CFG(1), .HOLD_CYCLES(HOLD), .UNLOCK_WAIT(UNLOCK), .LOCK_TIMEOUT(TIMEOUT)
  ) dut (
    .CLK_50M(CLK_50M), .reset_n(reset_n), .pal(pal), .pll_locked(pll_locked),
    .mgmt_waitrequest(mgmt_waitrequest), .mgmt_write(mgmt_write),
    .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
`ifdef PLL_MODE_SWITCH_READBACK_EN
    .mgmt_read(mgmt_read), .mgmt_readdata(mgmt_readdata),
`endif
    .tv_reset(tv_reset), .busy(busy), .done(done), .lock_err(lock_err), .cfg_err(cfg_err)
  );

  always #5 CLK_50M = ~CLK_50M;

  // Slave model and write monitor, evaluated between rising edges.
  always @(negedge CLK_50M) begin
    if (stall_en && mgmt_write && mgmt_address == 6'd4 && stall_cnt < 5) begin
      mgmt_waitrequest = 1'b1;
      stall_cnt++;
    end else begin
      mgmt_waitrequest = 1'b0;
    end
    if (mgmt_write && mgmt_address == 6'd4) wr4_cycles++;
    if (prev_stall) begin
      checks++;
      if (!(mgmt_write && mgmt_address == prev_addr && mgmt_writedata == prev_data)) begin
        errors++;
        $display("FAIL stall_hold: got write=%b addr=%h data=%h, expected write=1 addr=%h data=%h",
                 mgmt_write, mgmt_address, mgmt_writedata, prev_addr, prev_data);
      end
    end
    prev_stall = reset_n && mgmt_write && mgmt_waitrequest;
    prev_addr  = mgmt_address;
    prev_data  = mgmt_writedata;
    if (reset_n && mgmt_write && !mgmt_waitrequest) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%h data=%h, expected no write", mgmt_address, mgmt_writedata);
      end else begin
        exp_item = exp_q.pop_front();
        if ({mgmt_address, mgmt_writedata} !== exp_item) begin
          errors++;
          $display("FAIL write_seq: got addr=%h data=%h, expected addr=%h data=%h",
                   mgmt_address, mgmt_writedata, exp_item[37:32], exp_item[31:0]);
        end
      end
`ifdef PLL_MODE_SWITCH_READBACK_EN
      mem[mgmt_address[2:0]] = mgmt_writedata;
`endif
    end
`ifdef PLL_MODE_SWITCH_READBACK_EN
    if (mgmt_read)
      mgmt_readdata = mem[mgmt_address[2:0]] ^ ((corrupt && mgmt_address == 6'd5) ? 32'h1 : 32'h0);
    else
      mgmt_readdata = 32'd0;
`endif
  end

  task automatic step();
    @(posedge CLK_50M);
    #2;
  endtask

  task automatic push_writes(input logic m);
    exp_q.push_back({6'd0, 32'h00000000});
    exp_q.push_back({6'd3, 32'h00010000});
    exp_q.push_back({6'd4, 32'h00000404});
    exp_q.push_back({6'd5, m ? 32'h00020504 : 32'h00000505});
    exp_q.push_back({6'd7, m ? 32'hA3D709E8 : 32'h9745BF27});
    exp_q.push_back({6'd2, 32'h00000000});
  endtask

  task automatic wait_empty(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK_50M);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK_50M);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic ok;
    reset_n = 1'b0; pal = 1'b0; pll_locked = 1'b0; stall_en = 1'b0; stall_cnt = 0;
    mgmt_waitrequest = 1'b0; prev_stall = 1'b0; wr4_cycles = 0;
`ifdef PLL_MODE_SWITCH_READBACK_EN
    corrupt = 1'b0;
`endif
    repeat (5) @(posedge CLK_50M);
    @(negedge CLK_50M);
    checks++;
    if ({mgmt_write, tv_reset, busy, done, lock_err, cfg_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 000000",
               {mgmt_write, tv_reset, busy, done, lock_err, cfg_err});
    end
    checks++;
    if ({mgmt_address, mgmt_writedata} !== 38'd0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h data=%h, expected 0", mgmt_address, mgmt_writedata);
    end
    push_writes(1'b0);
    step();
    reset_n = 1'b1;
    repeat (4) @(negedge CLK_50M);
    checks++;
    if ({tv_reset, busy} !== 2'b11) begin
      errors++;
      $display("FAIL init_cfg_start: got tv_reset,busy=%b, expected 11", {tv_reset, busy});
    end
    wait_empty(80, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL init_writes: got %0d pending writes, expected 0", exp_q.size());
    end
  endtask

  // Lock rises after unlock: tv_reset must fall HOLD cycles after lock_s rises.
  task automatic test_lock_hold();
    repeat (3) step();
    pll_locked = 1'b1;
    repeat (HOLD + 2) @(negedge CLK_50M);
    checks++;
    if (tv_reset !== 1'b1) begin
      errors++;
      $display("FAIL hold_early: got tv_reset=%b, expected 1", tv_reset);
    end
    @(negedge CLK_50M);
    checks++;
    if ({tv_reset, busy, done, lock_err} !== 4'b0010) begin
      errors++;
      $display("FAIL hold_release: got tv_reset,busy,done,lock_err=%b, expected 0010",
               {tv_reset, busy, done, lock_err});
    end
    @(negedge CLK_50M);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b, expected 0", done);
    end
  endtask

  task automatic test_pal_toggle();
    logic ok;
    wr4_cycles = 0; stall_cnt = 0; stall_en = 1'b1;
    push_writes(1'b1);
    pal = 1'b1;
    wait_empty(100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pal_writes: got %0d pending writes, expected 0", exp_q.size());
    end
    @(negedge CLK_50M);
    stall_en = 1'b0;
    checks++;
    if (wr4_cycles != 6) begin
      errors++;
      $display("FAIL stall_cycles: got %0d write cycles on addr 4, expected 6", wr4_cycles);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    repeat (10) step();
    pal = 1'b0;
    push_writes(1'b0);
    wait_done(60, ok);
    checks++;
    if (!ok || {tv_reset, busy} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_first_done: got done_seen=%b tv_reset,busy=%b, expected 1 00",
               ok, {tv_reset, busy});
    end
    @(negedge CLK_50M);
    checks++;
    if ({tv_reset, busy} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_restart: got tv_reset,busy=%b, expected 11", {tv_reset, busy});
    end
    wait_empty(80, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_writes: got %0d pending writes, expected 0", exp_q.size());
    end
    wait_done(80, ok);
    checks++;
    if (!ok || {lock_err, cfg_err} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_second_done: got done_seen=%b lock_err,cfg_err=%b, expected 1 00",
               ok, {lock_err, cfg_err});
    end
  endtask

  task automatic test_lock_bounce();
    logic ok;
    step();
    pal = 1'b1;
    push_writes(1'b1);
    wait_empty(80, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bounce_writes: got %0d pending writes, expected 0", exp_q.size());
    end
    repeat (14) step();
    pll_locked = 1'b0;
    repeat (2) step();
    pll_locked = 1'b1;
    repeat (HOLD + 2) @(negedge CLK_50M);
    checks++;
    if (tv_reset !== 1'b1) begin
      errors++;
      $display("FAIL bounce_restart: got tv_reset=%b, expected 1", tv_reset);
    end
    @(negedge CLK_50M);
    checks++;
    if ({tv_reset, done} !== 2'b01) begin
      errors++;
      $display("FAIL bounce_release: got tv_reset,done=%b, expected 01", {tv_reset, done});
    end
  endtask

  task automatic test_lock_timeout();
    logic ok;
    step();
    pll_locked = 1'b0;
    pal = 1'b0;
    push_writes(1'b0);
    wait_empty(80, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_writes: got %0d pending writes, expected 0", exp_q.size());
    end
    repeat (150) @(negedge CLK_50M);
    checks++;
    if (lock_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got lock_err=%b, expected 0", lock_err);
    end
    repeat (70) @(negedge CLK_50M);
    checks++;
    if ({lock_err, tv_reset} !== 2'b11) begin
      errors++;
      $display("FAIL timeout_flag: got lock_err,tv_reset=%b, expected 11", {lock_err, tv_reset});
    end
    step();
    pll_locked = 1'b1;
    wait_done(60, ok);
    checks++;
    if (!ok || lock_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got done_seen=%b lock_err=%b, expected 1 1", ok, lock_err);
    end
  endtask

  task automatic test_reset_midwrite();
    logic ok;
    ok = 1'b0;
    step();
    stall_cnt = 0; stall_en = 1'b1;
    pal = 1'b1;
    push_writes(1'b1);
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK_50M);
      if (mgmt_write && mgmt_address == 6'd4) begin ok = 1'b1; break; end
    end
    step();
    reset_n = 1'b0;
    @(posedge CLK_50M);
    @(negedge CLK_50M);
    checks++;
    if (!ok || {mgmt_write, tv_reset, busy, lock_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_abort: got reached=%b write,tv_reset,busy,lock_err=%b, expected 1 0000",
               ok, {mgmt_write, tv_reset, busy, lock_err});
    end
    exp_q.delete();
    stall_en = 1'b0;
    repeat (3) step();
    push_writes(1'b1);
    reset_n = 1'b1;
    wait_empty(80, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL post_reset_writes: got %0d pending writes, expected 0", exp_q.size());
    end
    wait_done(60, ok);
    checks++;
    if (!ok || tv_reset !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_done: got done_seen=%b tv_reset=%b, expected 1 0", ok, tv_reset);
    end
  endtask

`ifdef PLL_MODE_SWITCH_READBACK_EN
  task automatic test_readback();
    logic ok;
    step();
    corrupt = 1'b1;
    pal = 1'b0;
    push_writes(1'b0);
    wait_empty(120, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL readback_writes: got %0d pending writes, expected 0", exp_q.size());
    end
    wait_done(60, ok);
    checks++;
    if (!ok || cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL readback_err: got done_seen=%b cfg_err=%b, expected 1 1", ok, cfg_err);
    end
    corrupt = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_lock_hold();
    test_pal_toggle();
    test_back_to_back();
    test_lock_bounce();
    test_lock_timeout();
    test_reset_midwrite();
`ifdef PLL_MODE_SWITCH_READBACK_EN
    test_readback();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
